register_file: RTL and testbench
================================

Name: register_file

Overview:
- Multi-port general-purpose register file for the MIPS-style datapath.
- REG_DEPTH words of DATA_WIDTH bits.
- One synchronous write port and RD_DEPTH independent read ports, with read addresses and read data packed into flat vectors.
- Sits between instruction decode (operand addresses) and the ALU/writeback stage.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- RD_DEPTH, 2, number of parallel read ports.
- REG_DEPTH, 32, number of registers; must be ≤ 2**ADDR_WIDTH.
- ADDR_WIDTH, 5, address width per port.
- DELAY, 0, number of output register stages on each read port (0 = combinational read).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-low reset.
- en_n, input, 1, active-low block enable.
- wr, input, 1, write enable (active high).
- rr, input, ADDR_WIDTH*RD_DEPTH, packed read addresses; port i uses rr[ADDR_WIDTH*(i+1)-1 : ADDR_WIDTH*i].
- rw, input, ADDR_WIDTH, write address.
- d, input, DATA_WIDTH, write data.
- q, output, DATA_WIDTH*RD_DEPTH, packed read data; port i on q[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].

Behaviour:
- Reset: on a rising clk with rst=0, all registers and all DELAY pipeline stages clear to 0. Reset has priority over write. Reset mid-operation discards any write in that cycle.
- Write: on a rising clk with rst=1, en_n=0, wr=1, the word at reg[rw] takes d. The write is visible on reads after that edge.
- Register 0 is hardwired to zero: writes to address 0 are ignored and reads of address 0 always return 0.
- Addresses ≥ REG_DEPTH: writes are ignored; reads return 0.
- Read, DELAY=0: each port is combinational. q slice i = reg[rr slice i] when en_n=0; q = 0 when en_n=1.
- Read, DELAY=N>0: the combinational value above passes through N rising-edge register stages, so latency is N cycles. Stages reset to 0.
- No write-to-read bypass: a read of rw in the same cycle as a write returns the old value until the clock edge.
- en_n=1:
  - writes are suppressed regardless of wr;
  - register contents are held;
  - q reads 0, and with DELAY>0 zeros enter the pipeline.
- Multiple read ports may address the same register simultaneously; all return the same value.
- wr and rw may change at any time between edges; only values at the rising edge matter.

Test Plan:
- Reset: hold rst=0 for 5 cycles, rr={5'd27,5'd4} → q=64'h0 after the first edge. Release rst, then read every address on both ports → all 0.
- Write/read port 1: d=32'hdcaf484c, rw=5'd27, pulse wr=1 for one edge, rr={27,4} → q=64'hdcaf484c_00000000. With wr=0 and d changed afterward, q is unchanged.
- Second write port 0: d=32'h37373737, rw=5'd4, pulse wr → q=64'hdcaf484c_37373737. Swap rr to {4,27} → q=64'h37373737_dcaf484c.
- r0 / enable: write 32'hffffffff to rw=0 → reading address 0 returns 0. Set en_n=1 and write 32'h12345678 to address 27 → q=0 while en_n=1. Return en_n=0 → address 27 still reads 32'hdcaf484c.
- Same-cycle read of write target: rr port 0 = rw = 5, d=32'haaaa5555, wr=1 → q port 0 shows the old value 0 before the edge and 32'haaaa5555 after it.
- DELAY=2 build: write 32'hcafe0001 to address 9, then set rr port 0 = 9 → q port 0 becomes 32'hcafe0001 exactly 2 edges later. Assert rst=0 mid-pipeline → q=0 after the next edge, and address 9 reads 0.

Source files
------------

// File: rtl/register_file.sv
// Multi-port register file: one synchronous write port, RD_DEPTH read ports,
// register 0 hardwired to zero, optional DELAY-stage output pipeline.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_DEPTH   = 2,
  parameter int REG_DEPTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DELAY      = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_n,
  input  logic                           wr,
  input  logic [ADDR_WIDTH*RD_DEPTH-1:0] rr,
  input  logic [ADDR_WIDTH-1:0]          rw,
  input  logic [DATA_WIDTH-1:0]          d,
  output logic [DATA_WIDTH*RD_DEPTH-1:0] q
);

  localparam int QW = DATA_WIDTH * RD_DEPTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(REG_DEPTH);

  logic [DATA_WIDTH-1:0] regs [REG_DEPTH];
  logic [QW-1:0]         rd_comb;
  logic                  wr_ok;

  // Address 0 and out-of-range addresses never hold data.
  function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < DEPTH_LIM);
  endfunction

  assign wr_ok = !en_n && wr && addr_live(rw);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rw] <= d;
    end
  end

  always_comb begin
    rd_comb = '0;
    for (int i = 0; i < RD_DEPTH; i++) begin
      if (!en_n && addr_live(rr[i*ADDR_WIDTH +: ADDR_WIDTH]))
        rd_comb[i*DATA_WIDTH +: DATA_WIDTH] = regs[rr[i*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  generate
    if (DELAY == 0) begin : g_comb
      assign q = rd_comb;
    end else begin : g_pipe
      logic [QW-1:0] stage [DELAY];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int k = 0; k < DELAY; k++) stage[k] <= '0;
        end else begin
          stage[0] <= rd_comb;
          for (int k = 1; k < DELAY; k++) stage[k] <= stage[k-1];
        end
      end

      assign q = stage[DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a combinational instance and a DELAY=2
// instance share stimulus and are checked every cycle against a bench model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst, en_n, wr;
  logic [9:0]  rr;
  logic [4:0]  rw;
  logic [31:0] d;
  logic [63:0] q0, q2;

  int checks = 0;
  int errors = 0;

  register_file #(.DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .en_n(en_n), .wr(wr), .rr(rr), .rw(rw), .d(d), .q(q0)
  );
  register_file #(.DELAY(2)) dut2 (
    .clk(clk), .rst(rst), .en_n(en_n), .wr(wr), .rr(rr), .rw(rw), .d(d), .q(q2)
  );

  always #5 clk = ~clk;

  // Model: plain array of words plus a two-entry history of read results.
  logic [31:0] mem [32];
  logic [63:0] hist0, hist1;
  bit          model_valid = 0;

  function automatic logic [63:0] expect_read(input logic [9:0] a, input logic off);
    logic [63:0] r;
    logic [4:0]  p;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      p = a[i*5 +: 5];
      if (!off && p != 0) r[i*32 +: 32] = mem[p];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      hist0 = '0;
      hist1 = '0;
    end else begin
      hist1 = hist0;
      hist0 = expect_read(rr, en_n);
      if (!en_n && wr && rw != 0) mem[rw] = d;
    end
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (q0 !== expect_read(rr, en_n)) begin
        errors++;
        $display("FAIL model_q0 t=%0t got=%h exp=%h", $time, q0, expect_read(rr, en_n));
      end
      checks++;
      if (q2 !== hist1) begin
        errors++;
        $display("FAIL model_q2 t=%0t got=%h exp=%h", $time, q2, hist1);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en_n = 1'b0; wr = 1'b0;
    rr = {5'd27, 5'd4}; rw = '0; d = '0;

    tick();
    check("reset_q", q0, 64'h0);
    repeat (4) tick();
    rst = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rr = {5'(a), 5'(a)};
      tick();
      check("reset_all", q0, 64'h0);
    end

    rr = {5'd27, 5'd4}; rw = 5'd27; d = 32'hdcaf484c; wr = 1'b1;
    tick();
    wr = 1'b0; d = 32'h11111111; #1;
    check("wr27", q0, 64'hdcaf484c_00000000);
    tick();
    check("wr27_hold", q0, 64'hdcaf484c_00000000);

    rw = 5'd4; d = 32'h37373737; wr = 1'b1;
    tick();
    wr = 1'b0; #1;
    check("wr4", q0, 64'hdcaf484c_37373737);
    rr = {5'd4, 5'd27}; #1;
    check("swap", q0, 64'h37373737_dcaf484c);

    rw = 5'd0; d = 32'hffffffff; wr = 1'b1;
    tick();
    wr = 1'b0; rr = '0; #1;
    check("r0", q0, 64'h0);

    en_n = 1'b1; rw = 5'd27; d = 32'h12345678; wr = 1'b1; rr = {5'd27, 5'd27}; #1;
    check("en_off", q0, 64'h0);
    tick();
    check("en_off_edge", q0, 64'h0);
    wr = 1'b0; en_n = 1'b0; #1;
    check("en_back", q0, 64'hdcaf484c_dcaf484c);

    rr = {5'd4, 5'd5}; rw = 5'd5; d = 32'haaaa5555; wr = 1'b1; #1;
    check("nobypass", {32'h0, q0[31:0]}, 64'h0);
    tick();
    wr = 1'b0; #1;
    check("after_wr5", {32'h0, q0[31:0]}, {32'h0, 32'haaaa5555});

    for (int k = 10; k < 16; k++) begin
      rw = 5'(k); d = 32'h0101_0000 * 32'(k) + 32'(k); wr = 1'b1;
      rr = {5'(k-1), 5'(k)};
      tick();
    end
    wr = 1'b0; rr = {5'd15, 5'd12}; #1;
    check("loop_read", q0, {32'h0f0f000f, 32'h0c0c000c});

    rr = {5'd27, 5'd4}; rw = 5'd9; d = 32'hcafe0001; wr = 1'b1;
    tick();
    wr = 1'b0; rr = {5'd27, 5'd9};
    tick();
    check("d2_edge1", {32'h0, q2[31:0]}, {32'h0, 32'h37373737});
    tick();
    check("d2_edge2", {32'h0, q2[31:0]}, {32'h0, 32'hcafe0001});

    rst = 1'b0;
    tick();
    check("d2_rst", q2, 64'h0);
    check("q0_rst", q0, 64'h0);
    rst = 1'b1;
    tick();
    check("r9_cleared", {32'h0, q0[31:0]}, 64'h0);
    tick();
    check("d2_after_rst", q2, 64'h0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
